signal_count_accumulator: RTL and testbench
===========================================

// Module: signal_count_accumulator
// PURPOSE
//  Downstream consumer of the 4-input signal-counting stage (3-bit popcount, 0..4).
//  Sums WINDOW accepted counts with a valid/ready handshake.
//  Presents the windowed total, with a sticky saturation flag, to the next stage.
//  Feeds the ARITHMETIC chain where per-cycle popcounts become a running tally.
// PARAMETERS
//  WINDOW  8  accepted samples per result; legal range >=1
//  SUM_W   6  width of out_sum; legal range >=3; sums saturate at 2**SUM_W-1
// PORTS
//  clk          in   1      single clock; all state updates on its rising edge
//  rst_n        in   1      synchronous, active-low reset, sampled on the rising edge of clk
//  in_valid     in   1      in_count is valid this cycle
//  in_ready     out  1      accumulator can take in_count this cycle
//  in_count     in   3      popcount from the counting stage, nominally 0..4
//  out_valid    out  1      out_sum/out_overflow hold a completed window
//  out_ready    in   1      consumer takes the result this cycle
//  out_sum      out  SUM_W  window total, saturated
//  out_overflow out  1      window total hit saturation or got a clamped input
//  out_peak     out  3      largest clamped in_count in the window (COUNT_ACC_PEAK_EN only)
// BEHAVIOUR
//  Reset (rst_n=0 at a clock edge): state=ACCUM; sum=0; sample_cnt=0; overflow=0; peak=0.
//    Outputs after reset: out_valid=0, out_sum=0, out_overflow=0, out_peak=0. in_ready=1.
//  Reset mid-window or mid-HOLD discards all partial and held data; no result is emitted.
//  Input accept:  acc_in  = in_valid & in_ready.
//  Output accept: acc_out = out_valid & out_ready.
//  in_ready = (state==ACCUM) | out_ready. This is combinational, so back-to-back windows lose no cycle.
//  FSM states: ACCUM, HOLD.
//  ACCUM:
//   - On acc_in: sum = sat(sum + clamp(in_count)); sample_cnt++.
//   - clamp(x) = (x>4) ? 4 : x. A clamp event sets overflow.
//   - If sample_cnt == WINDOW-1 on acc_in: go to HOLD and register the final values.
//     out_valid rises the next cycle, so latency from the last accept to out_valid is 1 cycle.
//   - out_valid=0 in ACCUM.
//  HOLD:
//   - out_valid=1. out_sum, out_overflow and out_peak stay stable until acc_out.
//   - acc_out without acc_in: go to ACCUM with sum=0, sample_cnt=0, overflow=0, peak=0.
//   - acc_out with acc_in in the same cycle: the sample is the first of a new window,
//     so sum=clamp(in_count) and sample_cnt=1.
//     If WINDOW==1, stay in HOLD and present the new result the next cycle.
//  Saturation: sat(a) = min(a, 2**SUM_W-1). Any saturating add sets overflow, which stays set until the window is consumed.
//  in_count must stay stable while in_valid=1 and in_ready=0; the bench asserts this.
//  Whole window accepted with no stalls: WINDOW accept cycles, then out_valid in the next cycle.
// CONFIGURATION
//  COUNT_ACC_PEAK_EN defined:
//   - Tracks peak = max(peak, clamp(in_count)) on each acc_in and drives out_peak.
//   - peak is cleared or reloaded exactly like sum.
//  COUNT_ACC_PEAK_EN undefined:
//   - The out_peak port does not exist.
//   - No peak register is built.
// STRUCTURE
//  Package count_acc_pkg:
//   - localparam COUNT_W=3 and MAX_COUNT=3'd4.
//   - typedef enum logic {ACCUM, HOLD} acc_state_t.
//   - function clamp_count().
//  Sub-module count_sat_adder #(SUM_W): combinational sum + clamped count -> saturated sum plus sat flag.
//   The FSM and registers stay in the top module.
// TESTING
//  1 Reset: hold rst_n=0 for 2 clocks with in_valid=1 -> out_valid=0, out_sum=0, in_ready=1.
//  2 Full window (WINDOW=8, SUM_W=6): in_count=3 for 8 accepts, out_ready=0.
//    -> out_valid next cycle, out_sum=24, out_overflow=0, in_ready=0 while held.
//  3 Saturation (SUM_W=3, WINDOW=8): in_count=4 x8 -> out_sum=7, out_overflow=1.
//    Then consume with out_ready=1 -> the next window starts at 0.
//  4 Back-to-back (WINDOW=2): counts 1,2 | 4,0 streamed with out_ready=1.
//    -> results 3 and 4, and in_valid is never stalled.
//  5 Illegal input: in_count=7 once in a window of zeros -> out_sum=4, out_overflow=1.
//    With COUNT_ACC_PEAK_EN: out_peak=4.
//  6 Reset mid-HOLD: drop rst_n while out_valid=1.
//    -> out_valid=0 and out_sum=0 the next cycle; the held result is never accepted.

Source files
------------

// File: rtl/count_acc_pkg.sv
// count_acc_pkg: shared widths, FSM state type and input clamp for the count accumulator
package count_acc_pkg;
  localparam int COUNT_W = 3;
  localparam logic [COUNT_W-1:0] MAX_COUNT = 3'd4;
  typedef enum logic {ACCUM, HOLD} acc_state_t;
  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] x);
    return (x > MAX_COUNT) ? MAX_COUNT : x;
  endfunction
endpackage

// File: rtl/count_sat_adder.sv
// count_sat_adder: adds a clamped count to a running sum, saturating at all-ones
module count_sat_adder
  import count_acc_pkg::*;
#(
  parameter int SUM_W = 6
) (
  input  logic [SUM_W-1:0]   sum,
  input  logic [COUNT_W-1:0] count,
  output logic [SUM_W-1:0]   result,
  output logic               sat
);
  logic [SUM_W:0] raw;
  // count <= 4 < 2**SUM_W, so the carry bit alone signals overflow
  assign raw = {1'b0, sum} + (SUM_W + 1)'(count);
  assign sat = raw[SUM_W];
  assign result = sat ? '1 : raw[SUM_W-1:0];
endmodule

// File: rtl/signal_count_accumulator.sv
// signal_count_accumulator: sums WINDOW popcounts per result; out_peak exists only with COUNT_ACC_PEAK_EN
module signal_count_accumulator
  import count_acc_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int SUM_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COUNT_W-1:0] in_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUM_W-1:0]   out_sum,
  output logic               out_overflow
`ifdef COUNT_ACC_PEAK_EN
  ,
  output logic [COUNT_W-1:0] out_peak
`endif
);
  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  acc_state_t state;
  logic [SUM_W-1:0] sum, base_sum, next_sum;
  logic [CW-1:0] cnt, base_cnt;
  logic ovf, base_ovf, sat, clamp_ev, acc_in, acc_out, fresh, last;
  logic [COUNT_W-1:0] c;
  assign in_ready = (state == ACCUM) | out_ready;
  assign out_valid = (state == HOLD);
  assign acc_in = in_valid & in_ready;
  assign acc_out = out_valid & out_ready;
  // an accept while in HOLD implies the held result is leaving, so start a new window
  assign fresh = (state == HOLD);
  assign base_sum = fresh ? '0 : sum;
  assign base_cnt = fresh ? '0 : cnt;
  assign base_ovf = fresh ? 1'b0 : ovf;
  assign c = clamp_count(in_count);
  assign clamp_ev = in_count > MAX_COUNT;
  assign last = base_cnt == CW'(WINDOW - 1);
  count_sat_adder #(.SUM_W(SUM_W)) u_add (
    .sum(base_sum), .count(c), .result(next_sum), .sat(sat)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
      sum   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (acc_in) begin
      state <= last ? HOLD : ACCUM;
      sum   <= next_sum;
      cnt   <= last ? '0 : base_cnt + CW'(1);
      ovf   <= base_ovf | sat | clamp_ev;
    end else if (acc_out) begin
      state <= ACCUM;
      sum   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end
  end
  assign out_sum = sum;
  assign out_overflow = ovf;
`ifdef COUNT_ACC_PEAK_EN
  logic [COUNT_W-1:0] peak, base_peak;
  assign base_peak = fresh ? '0 : peak;
  always_ff @(posedge clk) begin
    if (!rst_n) peak <= '0;
    else if (acc_in) peak <= (c > base_peak) ? c : base_peak;
    else if (acc_out) peak <= '0;
  end
  assign out_peak = peak;
`endif
endmodule

// File: tb/tb_signal_count_accumulator.sv
// tb_signal_count_accumulator: directed checks on three configurations (W8/S6, W8/S3, W2/S6)
module tb_signal_count_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v0 = 0, v1 = 0, v2 = 0, r0 = 0, r1 = 0, r2 = 0;
  logic [2:0] c0 = 0, c1 = 0, c2 = 0;
  logic ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
  logic [5:0] s0, s2;
  logic [2:0] s1;
`ifdef COUNT_ACC_PEAK_EN
  logic [2:0] pk0, pk1, pk2;
`endif
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  signal_count_accumulator #(.WINDOW(8), .SUM_W(6)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(ir0), .in_count(c0),
    .out_valid(ov0), .out_ready(r0), .out_sum(s0), .out_overflow(of0)
`ifdef COUNT_ACC_PEAK_EN
    , .out_peak(pk0)
`endif
  );
  signal_count_accumulator #(.WINDOW(8), .SUM_W(3)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .in_count(c1),
    .out_valid(ov1), .out_ready(r1), .out_sum(s1), .out_overflow(of1)
`ifdef COUNT_ACC_PEAK_EN
    , .out_peak(pk1)
`endif
  );
  signal_count_accumulator #(.WINDOW(2), .SUM_W(6)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2), .in_count(c2),
    .out_valid(ov2), .out_ready(r2), .out_sum(s2), .out_overflow(of2)
`ifdef COUNT_ACC_PEAK_EN
    , .out_peak(pk2)
`endif
  );

  // a stalled count must not change while the producer keeps it valid
  a_stable0: assert property (@(posedge clk) disable iff (!rst_n) (v0 && !ir0) |=> (!v0 || $stable(c0)));
  a_stable1: assert property (@(posedge clk) disable iff (!rst_n) (v1 && !ir1) |=> (!v1 || $stable(c1)));
  a_stable2: assert property (@(posedge clk) disable iff (!rst_n) (v2 && !ir2) |=> (!v2 || $stable(c2)));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; v0 = 0; v1 = 0; v2 = 0; r0 = 0; r1 = 0; r2 = 0;
    step(); step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; v0 = 1; c0 = 3;
    step(); step();
    checks++; if (ov0 !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", ov0); end
    checks++; if (s0 !== 6'd0) begin fails++; $display("FAIL reset_sum got %0d want 0", s0); end
    checks++; if (ir0 !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ir0); end
    checks++; if (of0 !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", of0); end
`ifdef COUNT_ACC_PEAK_EN
    checks++; if (pk0 !== 3'd0) begin fails++; $display("FAIL reset_peak got %0d want 0", pk0); end
`endif
    rst_n = 1; v0 = 0;
    step();
  endtask

  task automatic test_full_window();
    do_reset();
    v0 = 1; c0 = 3; r0 = 0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (ov0 !== 1'b0) begin fails++; $display("FAIL full_early_valid i=%0d got %b want 0", i, ov0); end
      step();
    end
    checks++; if (ov0 !== 1'b1) begin fails++; $display("FAIL full_valid got %b want 1", ov0); end
    checks++; if (s0 !== 6'd24) begin fails++; $display("FAIL full_sum got %0d want 24", s0); end
    checks++; if (of0 !== 1'b0) begin fails++; $display("FAIL full_ovf got %b want 0", of0); end
    checks++; if (ir0 !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", ir0); end
    step(); step();
    checks++; if (ov0 !== 1'b1 || s0 !== 6'd24) begin fails++; $display("FAIL full_hold got v=%b s=%0d want v=1 s=24", ov0, s0); end
    v0 = 0; r0 = 1;
    step();
    checks++; if (ov0 !== 1'b0) begin fails++; $display("FAIL full_consume got %b want 0", ov0); end
    r0 = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    v1 = 1; c1 = 4; r1 = 0;
    for (int i = 0; i < 8; i++) step();
    v1 = 0;
    checks++; if (ov1 !== 1'b1) begin fails++; $display("FAIL sat_valid got %b want 1", ov1); end
    checks++; if (s1 !== 3'd7) begin fails++; $display("FAIL sat_sum got %0d want 7", s1); end
    checks++; if (of1 !== 1'b1) begin fails++; $display("FAIL sat_ovf got %b want 1", of1); end
    r1 = 1;
    step();
    checks++; if (ov1 !== 1'b0) begin fails++; $display("FAIL sat_consume got %b want 0", ov1); end
    r1 = 0; v1 = 1;
    for (int i = 0; i < 8; i++) begin
      c1 = (i == 0) ? 3'd1 : 3'd0;
      step();
    end
    v1 = 0;
    checks++; if (ov1 !== 1'b1 || s1 !== 3'd1) begin fails++; $display("FAIL sat_next_sum got v=%b s=%0d want v=1 s=1", ov1, s1); end
    checks++; if (of1 !== 1'b0) begin fails++; $display("FAIL sat_next_ovf got %b want 0", of1); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] cnts [4];
    logic [5:0] exp_sum [4];
    logic       exp_v [4];
    cnts = '{3'd1, 3'd2, 3'd4, 3'd0};
    exp_v = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_sum = '{6'd0, 6'd3, 6'd0, 6'd4};
    do_reset();
    v2 = 1; r2 = 1;
    for (int i = 0; i < 4; i++) begin
      c2 = cnts[i];
      checks++; if (ir2 !== 1'b1) begin fails++; $display("FAIL b2b_stall i=%0d got ready=%b want 1", i, ir2); end
      step();
      checks++; if (ov2 !== exp_v[i]) begin fails++; $display("FAIL b2b_valid i=%0d got %b want %b", i, ov2, exp_v[i]); end
      if (exp_v[i]) begin
        checks++; if (s2 !== exp_sum[i] || of2 !== 1'b0) begin fails++; $display("FAIL b2b_sum i=%0d got s=%0d o=%b want s=%0d o=0", i, s2, of2, exp_sum[i]); end
      end
    end
    v2 = 0;
    step();
    checks++; if (ov2 !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b want 0", ov2); end
    r2 = 0;
  endtask

  task automatic test_illegal();
    do_reset();
    v0 = 1; r0 = 0;
    for (int i = 0; i < 8; i++) begin
      c0 = (i == 3) ? 3'd7 : 3'd0;
      step();
    end
    v0 = 0;
    checks++; if (ov0 !== 1'b1) begin fails++; $display("FAIL illegal_valid got %b want 1", ov0); end
    checks++; if (s0 !== 6'd4) begin fails++; $display("FAIL illegal_sum got %0d want 4", s0); end
    checks++; if (of0 !== 1'b1) begin fails++; $display("FAIL illegal_ovf got %b want 1", of0); end
`ifdef COUNT_ACC_PEAK_EN
    checks++; if (pk0 !== 3'd4) begin fails++; $display("FAIL illegal_peak got %0d want 4", pk0); end
`endif
  endtask

  task automatic test_reset_hold();
    do_reset();
    v0 = 1; c0 = 2; r0 = 0;
    for (int i = 0; i < 8; i++) step();
    v0 = 0;
    checks++; if (ov0 !== 1'b1 || s0 !== 6'd16) begin fails++; $display("FAIL rhold_pre got v=%b s=%0d want v=1 s=16", ov0, s0); end
    rst_n = 0; r0 = 1;
    step();
    checks++; if (ov0 !== 1'b0 || s0 !== 6'd0) begin fails++; $display("FAIL rhold_clear got v=%b s=%0d want v=0 s=0", ov0, s0); end
    rst_n = 1; r0 = 0;
    step();
    checks++; if (ov0 !== 1'b0 || of0 !== 1'b0) begin fails++; $display("FAIL rhold_after got v=%b o=%b want v=0 o=0", ov0, of0); end
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_saturation();
    test_back_to_back();
    test_illegal();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
